// File: rtl/alu_seq_if.sv
// Request/response bundle between the decode stage and the sequential ALU.
// The master issues an operation and the slave (the ALU) returns the result,
// the status flags and its handshake state.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       inst;
    logic [WIDTH-1:0] operand_1;
    logic [WIDTH-1:0] operand_2;
    logic             out_valid;
    logic [WIDTH-1:0] sol;
    logic             flag_z;
    logic             flag_c;
    logic             flag_n;
    logic             flag_v;
    logic             busy;

    modport master (
        output in_valid, inst, operand_1, operand_2,
        input  in_ready, out_valid, sol, flag_z, flag_c, flag_n, flag_v, busy
    );

    modport slave (
        input  in_valid, inst, operand_1, operand_2,
        output in_ready, out_valid, sol, flag_z, flag_c, flag_n, flag_v, busy
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arithmetic ops, iterative shift-add
// multiply and bit-serial left shift behind a valid/ready handshake.
// FSM: IDLE -> (EXEC for N cycles) -> DONE -> IDLE. Result and flags are
// only written on entry to DONE, so intermediate MUL/SHL values never leak.
module alu_seq #(
    parameter int WIDTH  = 8,
    parameter int MUL_EN = 1
) (
    input logic      clk,
    input logic      rst_n,
    alu_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] W_VAL   = WIDTH[WIDTH-1:0];
    localparam logic [CW-1:0]    CNT_MAX = CW'(WIDTH);

    localparam logic [2:0] OP_MUL = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_NOT = 3'd6;
    localparam logic [2:0] OP_SHL = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         inst_q, inst_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    // acc holds the running product for MUL, and the shift register for SHL
    // (bit WIDTH is then the most recent bit shifted out).
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   sol_q, sol_d;
    logic               flag_z_q, flag_z_d;
    logic               flag_c_q, flag_c_d;
    logic               flag_n_q, flag_n_d;
    logic               flag_v_q, flag_v_d;
    logic               out_valid_q, out_valid_d;

    logic [WIDTH:0]     sum_w;
    logic [WIDTH:0]     diff_w;
    logic [2*WIDTH-1:0] acc_step;
    logic               fin_en;
    logic [WIDTH-1:0]   fin_res;
    logic               fin_c;
    logic               fin_v;

    // Extended add/subtract: the extra top bit is carry out / unsigned borrow.
    assign sum_w  = {1'b0, bus.operand_1} + {1'b0, bus.operand_2};
    assign diff_w = {1'b0, bus.operand_1} - {1'b0, bus.operand_2};

    // Next-state, datapath step and result capture.
    always_comb begin
        state_d     = state_q;
        inst_d      = inst_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        sol_d       = sol_q;
        flag_z_d    = flag_z_q;
        flag_c_d    = flag_c_q;
        flag_n_d    = flag_n_q;
        flag_v_d    = flag_v_q;
        out_valid_d = 1'b0;
        acc_step    = acc_q;
        fin_en      = 1'b0;
        fin_res     = '0;
        fin_c       = 1'b0;
        fin_v       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    inst_d = bus.inst;
                    case (bus.inst)
                        OP_MUL: begin
                            if (MUL_EN != 0) begin
                                acc_d    = '0;
                                mcand_d  = {{WIDTH{1'b0}}, bus.operand_1};
                                mplier_d = bus.operand_2;
                                cnt_d    = CNT_MAX;
                                state_d  = S_EXEC;
                            end else begin
                                fin_en = 1'b1;
                            end
                        end
                        OP_ADD: begin
                            fin_en  = 1'b1;
                            fin_res = sum_w[WIDTH-1:0];
                            fin_c   = sum_w[WIDTH];
                            fin_v   = (bus.operand_1[WIDTH-1] == bus.operand_2[WIDTH-1]) &&
                                      (sum_w[WIDTH-1] != bus.operand_1[WIDTH-1]);
                        end
                        OP_SUB: begin
                            fin_en  = 1'b1;
                            fin_res = diff_w[WIDTH-1:0];
                            fin_c   = diff_w[WIDTH];
                            fin_v   = (bus.operand_1[WIDTH-1] != bus.operand_2[WIDTH-1]) &&
                                      (diff_w[WIDTH-1] != bus.operand_1[WIDTH-1]);
                        end
                        OP_AND: begin
                            fin_en  = 1'b1;
                            fin_res = bus.operand_1 & bus.operand_2;
                        end
                        OP_OR: begin
                            fin_en  = 1'b1;
                            fin_res = bus.operand_1 | bus.operand_2;
                        end
                        OP_XOR: begin
                            fin_en  = 1'b1;
                            fin_res = bus.operand_1 ^ bus.operand_2;
                        end
                        OP_NOT: begin
                            fin_en  = 1'b1;
                            fin_res = ~bus.operand_1;
                        end
                        default: begin
                            // SHL: a zero shift completes at once with no carry
                            if (bus.operand_2 == '0) begin
                                fin_en  = 1'b1;
                                fin_res = bus.operand_1;
                            end else begin
                                acc_d   = {{WIDTH{1'b0}}, bus.operand_1};
                                cnt_d   = (bus.operand_2 >= W_VAL) ? CNT_MAX
                                                                   : bus.operand_2[CW-1:0];
                                state_d = S_EXEC;
                            end
                        end
                    endcase
                end
            end
            S_EXEC: begin
                cnt_d = cnt_q - CW'(1);
                if (inst_q == OP_MUL) begin
                    acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                end else begin
                    acc_step = acc_q << 1;
                end
                acc_d = acc_step;
                if (cnt_q == CW'(1)) begin
                    fin_en  = 1'b1;
                    fin_res = acc_step[WIDTH-1:0];
                    fin_c   = (inst_q == OP_MUL) ? (|acc_step[2*WIDTH-1:WIDTH])
                                                 : acc_step[WIDTH];
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (fin_en) begin
            sol_d       = fin_res;
            flag_c_d    = fin_c;
            flag_v_d    = fin_v;
            flag_z_d    = (fin_res == '0);
            flag_n_d    = fin_res[WIDTH-1];
            out_valid_d = 1'b1;
            state_d     = S_DONE;
        end
    end

    // State and registered outputs; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            inst_q      <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            sol_q       <= '0;
            flag_z_q    <= 1'b0;
            flag_c_q    <= 1'b0;
            flag_n_q    <= 1'b0;
            flag_v_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            inst_q      <= inst_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            sol_q       <= sol_d;
            flag_z_q    <= flag_z_d;
            flag_c_q    <= flag_c_d;
            flag_n_q    <= flag_n_d;
            flag_v_q    <= flag_v_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.sol       = sol_q;
    assign bus.flag_z    = flag_z_q;
    assign bus.flag_c    = flag_c_q;
    assign bus.flag_n    = flag_n_q;
    assign bus.flag_v    = flag_v_q;
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=8, MUL_EN=1): directed corner cases, a held
// in_valid during MUL, a mid-MUL reset, then random operations checked
// against an arithmetic reference model.
module tb_alu_seq;
    localparam int W = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          n_vec = 0;
    int          n_bad = 0;
    int unsigned edge_cnt = 0;
    int unsigned acc_edge = 0;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W), .MUL_EN(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference: result, carry, overflow and EXEC length from plain arithmetic.
    function automatic void ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                   output logic [7:0] r, output logic c, output logic v,
                                   output int cycles);
        logic [15:0] p;
        logic [8:0]  s;
        int          amt;
        r = 8'h00; c = 1'b0; v = 1'b0; cycles = 0;
        case (op)
            3'd0: begin
                p = 16'(a) * 16'(b);
                r = p[7:0];
                c = (p[15:8] != 8'h00);
                cycles = 8;
            end
            3'd1: begin
                s = 9'(a) + 9'(b);
                r = s[7:0];
                c = s[8];
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            3'd2: begin
                r = a - b;
                c = (a < b);
                v = (a[7] != b[7]) && (r[7] != a[7]);
            end
            3'd3: r = a & b;
            3'd4: r = a | b;
            3'd5: r = a ^ b;
            3'd6: r = ~a;
            default: begin
                amt = (int'(b) > 8) ? 8 : int'(b);
                p = 16'(a) << amt;
                r = p[7:0];
                c = p[8];
                cycles = amt;
            end
        endcase
    endfunction

    task automatic wait_ready();
        int waited = 0;
        while (bus.in_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("in_ready_before_issue", {31'd0, bus.in_ready}, 32'd1);
    endtask

    // Issue one operation and check latency, result, flags and pulse width.
    // With hold=1, in_valid stays high with changing operands while busy.
    task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input bit hold);
        logic [7:0] r;
        logic       c, v;
        int         cycles;
        int         lat;
        bit         seen;
        ref_op(op, a, b, r, c, v, cycles);
        wait_ready();
        bus.in_valid  = 1'b1;
        bus.inst      = op;
        bus.operand_1 = a;
        bus.operand_2 = b;
        @(posedge clk);
        #1;
        acc_edge = edge_cnt;
        if (!hold) bus.in_valid = 1'b0;
        bus.inst      = 3'($urandom);
        bus.operand_1 = 8'($urandom);
        bus.operand_2 = 8'($urandom);
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            check("in_ready_while_busy", {31'd0, bus.in_ready}, 32'd0);
            if (bus.out_valid === 1'b1) seen = 1'b1;
            else if (hold) begin
                bus.inst      = 3'($urandom);
                bus.operand_1 = 8'($urandom);
                bus.operand_2 = 8'($urandom);
            end
        end
        bus.in_valid = 1'b0;
        check("out_valid_seen", {31'd0, seen}, 32'd1);
        check("latency", lat, cycles + 2);
        check("sol", {24'd0, bus.sol}, {24'd0, r});
        check("flag_z", {31'd0, bus.flag_z}, {31'd0, (r == 8'h00)});
        check("flag_c", {31'd0, bus.flag_c}, {31'd0, c});
        check("flag_n", {31'd0, bus.flag_n}, {31'd0, r[7]});
        check("flag_v", {31'd0, bus.flag_v}, {31'd0, v});
        check("busy_in_done", {31'd0, bus.busy}, 32'd1);
        $display("op=%0d a=%02h b=%02h -> sol=%02h z=%b c=%b n=%b v=%b lat=%0d (exp sol=%02h lat=%0d)",
                 op, a, b, bus.sol, bus.flag_z, bus.flag_c, bus.flag_n, bus.flag_v, lat, r, cycles + 2);
        @(negedge clk);
        check("out_valid_one_cycle", {31'd0, bus.out_valid}, 32'd0);
        check("sol_held", {24'd0, bus.sol}, {24'd0, r});
        check("in_ready_after_done", {31'd0, bus.in_ready}, 32'd1);
    endtask

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } vec_t;

    vec_t directed[$] = '{
        '{3'd1, 8'hF0, 8'h20}, '{3'd2, 8'h05, 8'h07}, '{3'd2, 8'h80, 8'h01},
        '{3'd0, 8'h0D, 8'h0B}, '{3'd0, 8'h10, 8'h10}, '{3'd7, 8'h81, 8'h03},
        '{3'd7, 8'h81, 8'h09}, '{3'd7, 8'h81, 8'h00}, '{3'd3, 8'hC3, 8'h5A},
        '{3'd4, 8'h00, 8'h00}, '{3'd5, 8'hA5, 8'hFF}, '{3'd6, 8'h0F, 8'h00},
        '{3'd1, 8'h7F, 8'h01}, '{3'd0, 8'hFF, 8'hFF}, '{3'd7, 8'h40, 8'hFF}
    };

    initial begin
        int unsigned first_acc;
        int          ov_count;
        logic [2:0]  op;
        logic [7:0]  a, b;

        bus.in_valid  = 1'b0;
        bus.inst      = 3'd0;
        bus.operand_1 = 8'h00;
        bus.operand_2 = 8'h00;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_sol", {24'd0, bus.sol}, 32'd0);
        check("rst_flags", {28'd0, bus.flag_z, bus.flag_c, bus.flag_n, bus.flag_v}, 32'd0);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (directed[i]) run_op(directed[i].op, directed[i].a, directed[i].b, 1'b0);

        // Held in_valid during MUL is ignored; next op accepted 10 edges later
        run_op(3'd0, 8'h0D, 8'h0B, 1'b1);
        first_acc = acc_edge;
        run_op(3'd1, 8'h11, 8'h22, 1'b0);
        check("accept_spacing", acc_edge - first_acc, 32'd10);

        // Reset in the middle of a MUL
        run_op(3'd1, 8'h12, 8'h34, 1'b0);
        wait_ready();
        bus.in_valid  = 1'b1;
        bus.inst      = 3'd0;
        bus.operand_1 = 8'hFF;
        bus.operand_2 = 8'hFF;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_sol", {24'd0, bus.sol}, 32'd0);
        check("midrst_flags", {28'd0, bus.flag_z, bus.flag_c, bus.flag_n, bus.flag_v}, 32'd0);
        check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ov_count = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) ov_count++;
        end
        check("no_out_valid_after_rst", ov_count, 32'd0);
        check("in_ready_after_rst", {31'd0, bus.in_ready}, 32'd1);
        run_op(3'd1, 8'h3C, 8'h44, 1'b0);

        // Random operations
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = 8'($urandom);
            b  = (op == 3'd7) ? 8'($urandom_range(0, 11)) : 8'($urandom);
            run_op(op, a, b, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
